absorb_ctrl: RTL and testbench

//  Sequences the F permutation across the message blocks of one absorb phase.

---
 rtl/absorb_pkg.sv | 20 ++
 rtl/absorb_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_absorb_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/absorb_pkg.sv
// Shared types and constants for the absorb-phase controller.
// Bit positions name the fields of the domain-separation word handed to F.
package absorb_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_FISSUE = 3'd3,
        S_FWAIT  = 3'd4,
        S_DONE   = 3'd5
    } absorb_state_e;

    localparam int DS_DOM_LSB   = 0;
    localparam int DS_LAST      = 2;
    localparam int DS_PAD       = 3;
    localparam int DS_FINAL     = 4;
    localparam int DS_WIDTH_DEF = 128;

endpackage

// File: rtl/absorb_ctrl.sv
// Sequences one F call per message block, plus an optional finalization call, then pulses done.
// ABSORB_CTRL_TIMEOUT_EN adds a per-call wait limit that aborts the job with err.
module absorb_ctrl
    import absorb_pkg::*;
#(
    parameter int NUMBLOCKS      = 4,
    parameter int DS_WIDTH       = DS_WIDTH_DEF,
`ifdef ABSORB_CTRL_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    localparam int IDXW = $clog2(NUMBLOCKS),
    localparam int CNTW = $clog2(NUMBLOCKS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNTW-1:0]     nblocks,
    input  logic                padded,
    input  logic                finalize,
    input  logic [1:0]          domain,
    input  logic                f_done,
    output logic                f_start,
    output logic [DS_WIDTH-1:0] f_ds,
    output logic [IDXW-1:0]     blk_idx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [CNTW-1:0] NB_MAX  = CNTW'(NUMBLOCKS);
    localparam logic [CNTW-1:0] NB_ONE  = CNTW'(1);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    absorb_state_e   state_q, state_d;
    logic [CNTW-1:0] nblocks_q, nblocks_d;
    logic            padded_q, padded_d;
    logic            finalize_q, finalize_d;
    logic [1:0]      domain_q, domain_d;
    logic [IDXW-1:0] blk_idx_q, blk_idx_d;
    logic [CNTW-1:0] nb_clamped;
    logic            last_blk;
    logic            timeout;
    logic [DS_WIDTH-1:0] ds_c;

    assign nb_clamped = (nblocks > NB_MAX) ? NB_MAX : nblocks;
    assign last_blk   = (CNTW'(blk_idx_q) == (nblocks_q - NB_ONE));

`ifdef ABSORB_CTRL_TIMEOUT_EN
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TOW-1:0] WCNT_LIMIT = TOW'(TIMEOUT_CYCLES - 1);

    logic [TOW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;

    assign timeout = (wcnt_q == WCNT_LIMIT);

    // Counter runs only while waiting on F, so every wait state entry starts from zero.
    always_comb begin
        wcnt_d = '0;
        if ((state_q == S_WAIT || state_q == S_FWAIT) && !timeout) begin
            wcnt_d = wcnt_q + TOW'(1);
        end else if (state_q == S_WAIT || state_q == S_FWAIT) begin
            wcnt_d = wcnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = (state_q == S_DONE) && err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        nblocks_d  = nblocks_q;
        padded_d   = padded_q;
        finalize_d = finalize_q;
        domain_d   = domain_q;
        blk_idx_d  = blk_idx_q;
`ifdef ABSORB_CTRL_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                blk_idx_d = '0;
`ifdef ABSORB_CTRL_TIMEOUT_EN
                err_d     = 1'b0;
`endif
                if (start) begin
                    nblocks_d  = nb_clamped;
                    padded_d   = padded;
                    finalize_d = finalize;
                    domain_d   = domain;
                    if (nb_clamped != '0) begin
                        state_d = S_ISSUE;
                    end else if (finalize) begin
                        state_d = S_FISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE:  state_d = S_WAIT;
            S_FISSUE: state_d = S_FWAIT;
            S_WAIT: begin
                if (f_done) begin
                    if (last_blk) begin
                        state_d = finalize_q ? S_FISSUE : S_DONE;
                    end else begin
                        blk_idx_d = blk_idx_q + IDX_ONE;
                        state_d   = S_ISSUE;
                    end
                end else if (timeout) begin
                    state_d = S_DONE;
`ifdef ABSORB_CTRL_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            S_FWAIT: begin
                if (f_done) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_DONE;
`ifdef ABSORB_CTRL_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            S_DONE: begin
                blk_idx_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            nblocks_q  <= '0;
            padded_q   <= 1'b0;
            finalize_q <= 1'b0;
            domain_q   <= '0;
            blk_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            nblocks_q  <= nblocks_d;
            padded_q   <= padded_d;
            finalize_q <= finalize_d;
            domain_q   <= domain_d;
            blk_idx_q  <= blk_idx_d;
        end
    end

    // The finalization call never carries the last/padding flags.
    always_comb begin
        ds_c = '0;
        case (state_q)
            S_ISSUE, S_WAIT: begin
                ds_c[DS_DOM_LSB +: 2] = domain_q;
                ds_c[DS_LAST]         = last_blk;
                ds_c[DS_PAD]          = padded_q & last_blk;
            end
            S_FISSUE, S_FWAIT: begin
                ds_c[DS_DOM_LSB +: 2] = domain_q;
                ds_c[DS_FINAL]        = 1'b1;
            end
            default: ds_c = '0;
        endcase
    end

    assign f_ds    = ds_c;
    assign f_start = (state_q == S_ISSUE) || (state_q == S_FISSUE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign blk_idx = blk_idx_q;

endmodule

// File: tb/tb_absorb_ctrl.sv
// Bench for absorb_ctrl: an F responder model answers each f_start, and a scoreboard
// of expected (f_ds, blk_idx) per call is popped as each f_start appears.
module tb_absorb_ctrl;

    localparam int NB   = 4;
    localparam int DSW  = 128;
    localparam int IDXW = $clog2(NB);
    localparam int CNTW = $clog2(NB + 1);

    logic            clk;
    logic            reset;
    logic            start;
    logic [CNTW-1:0] nblocks;
    logic            padded;
    logic            finalize;
    logic [1:0]      domain;
    logic            f_done;
    logic            f_start;
    logic [DSW-1:0]  f_ds;
    logic [IDXW-1:0] blk_idx;
    logic            busy;
    logic            done;
    logic            err;

    typedef struct {
        logic [DSW-1:0]  ds;
        logic [IDXW-1:0] idx;
        bit              chk_idx;
    } exp_t;

    exp_t exp_q[$];

    int vectors    = 0;
    int miscompare = 0;
    int cyc        = 0;
    int fstart_cnt = 0;
    int done_cnt   = 0;
    int done_cyc   = 0;
    int fdone_cyc  = 0;
    int cd         = 0;
    int f_delay    = 5;
    bit f_resp_en  = 1'b1;
    bit force_fdone = 1'b0;
    logic last_err = 1'b0;

    absorb_ctrl #(
        .NUMBLOCKS(NB),
`ifdef ABSORB_CTRL_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .DS_WIDTH(DSW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .nblocks(nblocks),
        .padded(padded),
        .finalize(finalize),
        .domain(domain),
        .f_done(f_done),
        .f_start(f_start),
        .f_ds(f_ds),
        .blk_idx(blk_idx),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor, scoreboard pop and F responder model.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (reset) begin
            cd = 0;
        end else begin
            if (f_start) begin
                fstart_cnt = fstart_cnt + 1;
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    miscompare = miscompare + 1;
                    $display("FAIL unexpected_f_start: got f_ds=%0h blk_idx=%0d, expected no call", f_ds, blk_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (f_ds !== e.ds || (e.chk_idx && blk_idx !== e.idx)) begin
                        miscompare = miscompare + 1;
                        $display("FAIL call_fields: got f_ds=%0h blk_idx=%0d, expected f_ds=%0h blk_idx=%0d",
                                 f_ds, blk_idx, e.ds, e.idx);
                    end
                end
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                last_err = err;
            end
        end
        f_done = force_fdone;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                f_done = 1'b1;
                fdone_cyc = cyc;
            end
        end
        if (!reset && f_start && f_resp_en) cd = f_delay;
    end

    task automatic start_job(input int nb, input bit pad, input bit fin, input int dom);
        int n;
        exp_t e;
        n = (nb > NB) ? NB : nb;
        for (int i = 0; i < n; i++) begin
            e.ds = '0;
            e.ds[1:0] = dom[1:0];
            e.ds[2] = (i == n - 1);
            e.ds[3] = pad && (i == n - 1);
            e.idx = i[IDXW-1:0];
            e.chk_idx = 1'b1;
            exp_q.push_back(e);
        end
        if (fin) begin
            e.ds = '0;
            e.ds[1:0] = dom[1:0];
            e.ds[4] = 1'b1;
            e.idx = '0;
            e.chk_idx = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        nblocks  = nb[CNTW-1:0];
        padded   = pad;
        finalize = fin;
        domain   = dom[1:0];
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int bound, input int d0, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        vectors = vectors + 1;
        if (!seen) begin
            miscompare = miscompare + 1;
            $display("FAIL %s_timeout: no done within %0d cycles, expected done", name, bound);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vectors = vectors + 1;
        if ({busy, done, err, f_start} !== 4'b0000) begin
            miscompare = miscompare + 1;
            $display("FAIL reset_ctrl: got busy/done/err/f_start=%b, expected 0000", {busy, done, err, f_start});
        end
        vectors = vectors + 1;
        if (f_ds !== '0 || blk_idx !== '0) begin
            miscompare = miscompare + 1;
            $display("FAIL reset_data: got f_ds=%0h blk_idx=%0d, expected 0 0", f_ds, blk_idx);
        end
    endtask

    task automatic test_basic();
        int d0, s0;
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(4, 1'b1, 1'b0, 2);
        vectors = vectors + 1;
        if (f_start !== 1'b1) begin
            miscompare = miscompare + 1;
            $display("FAIL basic_start_latency: got f_start=%b one cycle after start, expected 1", f_start);
        end
        wait_done(200, d0, "basic");
        repeat (3) @(negedge clk);
        #1;
        vectors = vectors + 1;
        if (done_cnt - d0 != 1 || fstart_cnt - s0 != 4 || exp_q.size() != 0) begin
            miscompare = miscompare + 1;
            $display("FAIL basic_counts: got done=%0d calls=%0d left=%0d, expected 1 4 0",
                     done_cnt - d0, fstart_cnt - s0, exp_q.size());
        end
        vectors = vectors + 1;
        if (last_err !== 1'b0 || done_cyc != fdone_cyc + 1) begin
            miscompare = miscompare + 1;
            $display("FAIL basic_done: got err=%b done_gap=%0d, expected err=0 gap=1", last_err, done_cyc - fdone_cyc);
        end
    endtask

    task automatic test_finalize();
        int d0, s0;
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(1, 1'b0, 1'b1, 1);
        wait_done(100, d0, "finalize");
        #1;
        vectors = vectors + 1;
        if (fstart_cnt - s0 != 2 || exp_q.size() != 0 || done_cyc != fdone_cyc + 1) begin
            miscompare = miscompare + 1;
            $display("FAIL finalize_seq: got calls=%0d left=%0d gap=%0d, expected 2 0 1",
                     fstart_cnt - s0, exp_q.size(), done_cyc - fdone_cyc);
        end
    endtask

    task automatic test_zero_blocks();
        int d0, s0;
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(0, 1'b0, 1'b0, 3);
        vectors = vectors + 1;
        if (done !== 1'b1 || f_start !== 1'b0) begin
            miscompare = miscompare + 1;
            $display("FAIL zero_done_latency: got done=%b f_start=%b one cycle after start, expected 1 0", done, f_start);
        end
        repeat (2) @(negedge clk);
        #1;
        vectors = vectors + 1;
        if (fstart_cnt != s0 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            miscompare = miscompare + 1;
            $display("FAIL zero_empty_job: got calls=%0d done=%0d busy=%b, expected 0 1 0",
                     fstart_cnt - s0, done_cnt - d0, busy);
        end
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(0, 1'b1, 1'b1, 0);
        wait_done(100, d0, "zero_final");
        #1;
        vectors = vectors + 1;
        if (fstart_cnt - s0 != 1 || exp_q.size() != 0) begin
            miscompare = miscompare + 1;
            $display("FAIL zero_final_calls: got calls=%0d left=%0d, expected 1 0", fstart_cnt - s0, exp_q.size());
        end
    endtask

    task automatic test_busy_start();
        int d0, s0;
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(3, 1'b0, 1'b0, 1);
        repeat (2) @(negedge clk);
        nblocks = 3'd1; finalize = 1'b1; domain = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, d0, "busy_start");
        repeat (4) @(negedge clk);
        #1;
        vectors = vectors + 1;
        if (fstart_cnt - s0 != 3 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
            miscompare = miscompare + 1;
            $display("FAIL busy_start_ignored: got calls=%0d left=%0d done=%0d, expected 3 0 1",
                     fstart_cnt - s0, exp_q.size(), done_cnt - d0);
        end
        d0 = done_cnt; s0 = fstart_cnt;
        @(posedge clk);
        #1 force_fdone = 1'b1;
        @(posedge clk);
        #1 force_fdone = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        vectors = vectors + 1;
        if (busy !== 1'b0 || done_cnt != d0 || fstart_cnt != s0) begin
            miscompare = miscompare + 1;
            $display("FAIL stray_f_done: got busy=%b done=%0d calls=%0d, expected 0 0 0",
                     busy, done_cnt - d0, fstart_cnt - s0);
        end
    endtask

    task automatic test_clamp();
        int d0, s0;
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(6, 1'b1, 1'b0, 1);
        wait_done(200, d0, "clamp");
        #1;
        vectors = vectors + 1;
        if (fstart_cnt - s0 != 4 || exp_q.size() != 0) begin
            miscompare = miscompare + 1;
            $display("FAIL clamp_calls: got calls=%0d left=%0d, expected 4 0", fstart_cnt - s0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_job();
        int d0, s0;
        bit found;
        found = 1'b0;
        start_job(4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 200; i++) begin
            #1;
            if (busy && !f_start && blk_idx == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors = vectors + 1;
        if (!found) begin
            miscompare = miscompare + 1;
            $display("FAIL reset_mid_reach: got no WAIT of block 2, expected one");
        end
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectors = vectors + 1;
        if ({busy, done, err, f_start} !== 4'b0000 || f_ds !== '0 || blk_idx !== '0) begin
            miscompare = miscompare + 1;
            $display("FAIL reset_mid_outputs: got busy/done/err/f_start=%b f_ds=%0h blk_idx=%0d, expected all 0",
                     {busy, done, err, f_start}, f_ds, blk_idx);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        #1;
        vectors = vectors + 1;
        if (done_cnt != d0) begin
            miscompare = miscompare + 1;
            $display("FAIL reset_mid_no_done: got %0d done pulses, expected 0", done_cnt - d0);
        end
        d0 = done_cnt; s0 = fstart_cnt;
        start_job(2, 1'b1, 1'b0, 3);
        wait_done(200, d0, "after_reset");
        #1;
        vectors = vectors + 1;
        if (fstart_cnt - s0 != 2 || exp_q.size() != 0 || last_err !== 1'b0) begin
            miscompare = miscompare + 1;
            $display("FAIL after_reset_job: got calls=%0d left=%0d err=%b, expected 2 0 0",
                     fstart_cnt - s0, exp_q.size(), last_err);
        end
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        f_resp_en = 1'b0;
        start_job(1, 1'b0, 1'b0, 0);
`ifdef ABSORB_CTRL_TIMEOUT_EN
        wait_done(40, d0, "timeout");
        #1;
        vectors = vectors + 1;
        if (last_err !== 1'b1 || done_cnt - d0 != 1) begin
            miscompare = miscompare + 1;
            $display("FAIL timeout_abort: got err=%b done=%0d, expected 1 1", last_err, done_cnt - d0);
        end
`else
        repeat (40) @(negedge clk);
        #1;
        vectors = vectors + 1;
        if (busy !== 1'b1 || done_cnt != d0) begin
            miscompare = miscompare + 1;
            $display("FAIL wait_holds: got busy=%b done=%0d, expected 1 0", busy, done_cnt - d0);
        end
        pulse_reset();
`endif
        f_resp_en = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; nblocks = '0; padded = 1'b0;
        finalize = 1'b0; domain = '0; f_done = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_finalize();
        test_zero_blocks();
        test_busy_start();
        test_clamp();
        test_reset_mid_job();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompare);
        $finish;
    end

endmodule
